i2s_tx_sched: RTL and testbench

//  Sample scheduler in front of i2s_tx: answers each per-frame rd_en request with one stereo pair.

---
 rtl/i2s_tx_sched.sv | 139 +++++++++++++
 tb/tb_i2s_tx_sched.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_sched.sv
// Per-frame stereo sample scheduler for i2s_tx: serves each rd_en request with one L/R pair
// from the runtime-selected source, with frame-aligned muting and timeout-driven underrun handling.
module i2s_tx_sched #(
    parameter int DW      = 24,
    parameter int NSRC    = 2,
    parameter int TIMEOUT = 16,
    parameter int UCNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(NSRC)-1:0] src_sel,
    input  logic                    mute,
    input  logic [NSRC*DW-1:0]      src_l,
    input  logic [NSRC*DW-1:0]      src_r,
    input  logic [NSRC-1:0]         src_valid,
    output logic [NSRC-1:0]         src_ready,
    input  logic                    rd_en,
    output logic                    rd_valid,
    output logic [DW-1:0]           l_sample,
    output logic [DW-1:0]           r_sample,
    output logic [$clog2(NSRC)-1:0] active_sel,
    output logic                    underrun,
    output logic [UCNT_W-1:0]       underrun_cnt
);

    localparam int SEL_W = $clog2(NSRC);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [TMR_W-1:0]   timer_r;
    logic               mute_r;
    logic               accept_s;
    logic               hs_s;
    logic               timeout_s;
    logic               sel_valid_s;
    logic [SEL_W-1:0]   sel_clamp_s;
    logic [DW-1:0]      sel_l_s;
    logic [DW-1:0]      sel_r_s;

    // Selected-source data mux, request clamping and frame event decode
    always_comb begin
        sel_l_s     = src_l[DW*int'(active_sel) +: DW];
        sel_r_s     = src_r[DW*int'(active_sel) +: DW];
        sel_valid_s = src_valid[active_sel];
        // Out-of-range requests fall back to source 0 rather than an undefined slice
        if (int'(src_sel) < NSRC) begin
            sel_clamp_s = src_sel;
        end else begin
            sel_clamp_s = {SEL_W{1'b0}};
        end
        accept_s  = (state_r == S_IDLE) && rd_en;
        hs_s      = (state_r == S_WAIT) && sel_valid_s;
        timeout_s = (state_r == S_WAIT) && !sel_valid_s &&
                    (timer_r == TMR_W'(TIMEOUT - 1));
    end

    // Next-state logic: a frame ends on either a handshake or a timeout
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (hs_s || timeout_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Pop strobe goes only to the latched source and only while waiting on it
    always_comb begin
        src_ready = {NSRC{1'b0}};
        if (state_r == S_WAIT) begin
            src_ready[active_sel] = 1'b1;
        end else begin
            src_ready = {NSRC{1'b0}};
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame datapath: latch selection/mute on accept, time the wait, register outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r      <= {TMR_W{1'b0}};
            mute_r       <= 1'b0;
            active_sel   <= {SEL_W{1'b0}};
            rd_valid     <= 1'b0;
            underrun     <= 1'b0;
            l_sample     <= {DW{1'b0}};
            r_sample     <= {DW{1'b0}};
            underrun_cnt <= {UCNT_W{1'b0}};
        end else begin
            rd_valid <= hs_s || timeout_s;
            underrun <= timeout_s;
            if (accept_s) begin
                active_sel <= sel_clamp_s;
                mute_r     <= mute;
                timer_r    <= {TMR_W{1'b0}};
            end else if ((state_r == S_WAIT) && !hs_s && !timeout_s) begin
                timer_r <= timer_r + TMR_W'(1);
            end
            // Muted frames still consume the pair so sources stay frame-aligned
            if (hs_s) begin
                l_sample <= mute_r ? {DW{1'b0}} : sel_l_s;
                r_sample <= mute_r ? {DW{1'b0}} : sel_r_s;
            end else if (timeout_s) begin
                l_sample <= {DW{1'b0}};
                r_sample <= {DW{1'b0}};
            end
            if (timeout_s && (underrun_cnt != {UCNT_W{1'b1}})) begin
                underrun_cnt <= underrun_cnt + UCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_sched.sv
// Directed self-checking bench for i2s_tx_sched (NSRC=2, DW=24, TIMEOUT=16, 4-bit underrun counter).
module tb_i2s_tx_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  src_sel;
    logic        mute;
    logic [47:0] src_l;
    logic [47:0] src_r;
    logic [1:0]  src_valid;
    logic [1:0]  src_ready;
    logic        rd_en;
    logic        rd_valid;
    logic [23:0] l_sample;
    logic [23:0] r_sample;
    logic [0:0]  active_sel;
    logic        underrun;
    logic [3:0]  underrun_cnt;

    int passed = 0;
    int total  = 0;
    int upulses = 0;

    i2s_tx_sched #(.DW(24), .NSRC(2), .TIMEOUT(16), .UCNT_W(4)) dut (
        .clk(clk), .rst(rst), .src_sel(src_sel), .mute(mute),
        .src_l(src_l), .src_r(src_r), .src_valid(src_valid), .src_ready(src_ready),
        .rd_en(rd_en), .rd_valid(rd_valid), .l_sample(l_sample), .r_sample(r_sample),
        .active_sel(active_sel), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (underrun) upulses <= upulses + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; src_sel = 1'b0; mute = 1'b0; rd_en = 1'b0;
        src_l = 48'h0; src_r = 48'h0; src_valid = 2'b00;
        tick(); tick();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_l", l_sample, 0);
        chk("rst_cnt", underrun_cnt, 0);
        chk("rst_ready", src_ready, 0);
        chk("rst_active", active_sel, 0);
        rst = 1'b0;
        tick();

        // 1: basic frame from source 0
        src_l = {24'h0, 24'h123456}; src_r = {24'h0, 24'hABCDEF}; src_valid = 2'b01;
        rd_en = 1'b1;
        tick(); rd_en = 1'b0;
        chk("t1_ready", src_ready, 2'b01);
        chk("t1_early_valid", rd_valid, 0);
        tick();
        chk("t1_rd_valid", rd_valid, 1);
        chk("t1_l", l_sample, 24'h123456);
        chk("t1_r", r_sample, 24'hABCDEF);
        chk("t1_cnt", underrun_cnt, 0);
        chk("t1_ready_off", src_ready, 0);
        src_valid = 2'b00;
        tick();
        chk("t1_pulse", rd_valid, 0);

        // 2: src_sel change during WAIT has no effect on the current frame
        src_l = {24'h111111, 24'h333333}; src_r = {24'h222222, 24'h444444};
        src_sel = 1'b0; rd_en = 1'b1;
        tick(); rd_en = 1'b0; src_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_ready_wait", src_ready, 2'b01);
            chk("t2_no_valid", rd_valid, 0);
            if (i < 4) tick();
        end
        src_valid = 2'b11;
        tick();
        chk("t2_rd_valid", rd_valid, 1);
        chk("t2_l", l_sample, 24'h333333);
        chk("t2_r", r_sample, 24'h444444);
        chk("t2_active0", active_sel, 0);
        rd_en = 1'b1;
        tick(); rd_en = 1'b0;
        chk("t2_active1", active_sel, 1);
        chk("t2_ready1", src_ready, 2'b10);
        tick();
        chk("t2_rd_valid1", rd_valid, 1);
        chk("t2_l1", l_sample, 24'h111111);
        chk("t2_r1", r_sample, 24'h222222);
        src_valid = 2'b00;

        // 3: selected source never valid -> timeout at t+17
        src_sel = 1'b0; src_valid = 2'b10; rd_en = 1'b1;
        tick(); rd_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            chk("t3_ready_only0", src_ready, 2'b01);
            chk("t3_no_valid", rd_valid, 0);
            chk("t3_no_underrun", underrun, 0);
            if (i < 16) tick();
        end
        tick();
        chk("t3_rd_valid", rd_valid, 1);
        chk("t3_underrun", underrun, 1);
        chk("t3_l_zero", l_sample, 0);
        chk("t3_r_zero", r_sample, 0);
        chk("t3_cnt", underrun_cnt, 1);
        tick();
        chk("t3_underrun_pulse", underrun, 0);
        chk("t3_rd_valid_pulse", rd_valid, 0);

        // 4: mute latched at rd_en; later mute changes ignored
        src_l = {24'h0, 24'h7FFFFF}; src_r = {24'h0, 24'h7FFFFF}; src_valid = 2'b01;
        mute = 1'b1; rd_en = 1'b1;
        tick(); rd_en = 1'b0; mute = 1'b0;
        chk("t4_pop", src_ready, 2'b01);
        tick();
        chk("t4_rd_valid", rd_valid, 1);
        chk("t4_l_muted", l_sample, 0);
        chk("t4_r_muted", r_sample, 0);
        chk("t4_single_pop", src_ready, 0);
        mute = 1'b0; rd_en = 1'b1;
        tick(); rd_en = 1'b0; mute = 1'b1;
        tick();
        chk("t4b_rd_valid", rd_valid, 1);
        chk("t4b_l", l_sample, 24'h7FFFFF);
        chk("t4b_r", r_sample, 24'h7FFFFF);
        mute = 1'b0; src_valid = 2'b00;

        // 5: 17 back-to-back timeouts; counter saturates at 15
        for (int k = 0; k < 17; k++) begin
            rd_en = 1'b1;
            tick(); rd_en = 1'b0;
            repeat (15) tick();
            chk("t5_pre_valid", rd_valid, 0);
            tick();
            chk("t5_rd_valid", rd_valid, 1);
            chk("t5_underrun", underrun, 1);
            chk("t5_cnt", underrun_cnt, (k + 2 > 15) ? 15 : k + 2);
        end
        tick();
        chk("t5_pulse_total", upulses, 18);
        chk("t5_cnt_sat", underrun_cnt, 4'hF);

        // 6: reset in WAIT clears everything immediately and drops the request
        src_l = {24'h0, 24'h5A5A5A}; src_r = {24'h0, 24'hA5A5A5};
        src_sel = 1'b1; rd_en = 1'b1;
        tick(); rd_en = 1'b0;
        chk("t6_active_pre", active_sel, 1);
        chk("t6_ready_pre", src_ready, 2'b10);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_ready", src_ready, 0);
        chk("t6_rst_active", active_sel, 0);
        chk("t6_rst_cnt", underrun_cnt, 0);
        chk("t6_rst_valid", rd_valid, 0);
        src_valid = 2'b11;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("t6_no_valid_a", rd_valid, 0);
        tick();
        chk("t6_no_valid_b", rd_valid, 0);
        chk("t6_idle_ready", src_ready, 0);
        src_sel = 1'b0; src_valid = 2'b01; rd_en = 1'b1;
        tick(); rd_en = 1'b0;
        chk("t6_ready", src_ready, 2'b01);
        tick();
        chk("t6_rd_valid", rd_valid, 1);
        chk("t6_l", l_sample, 24'h5A5A5A);
        chk("t6_r", r_sample, 24'hA5A5A5);
        chk("t6_cnt", underrun_cnt, 0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
